// File: rtl/register_file_pkg.sv
// Shared CPU constants used by the register file and its scoreboard.
package register_file_pkg;

   localparam int CPU_DATA_W = 32;
   localparam int CPU_ADDR_W = 5;
   localparam int REG_ZERO   = 0;

   // Register zero is hardwired, so it is never written, never busy and never bypassed.
   function automatic logic isWritable(input logic [CPU_ADDR_W-1:0] addr);
      return addr != CPU_ADDR_W'(REG_ZERO);
   endfunction

endpackage

// File: rtl/register_file_scoreboard.sv
// Busy-bit scoreboard: one bit per register marks an issued, not yet written-back producer.
module reg_scoreboard
   import register_file_pkg::*;
#(
   parameter int ADDR_W = CPU_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              set_en_i,
   input  logic [ADDR_W-1:0] set_addr_i,
   input  logic              clr_en_i,
   input  logic [ADDR_W-1:0] clr_addr_i,
   input  logic [ADDR_W-1:0] lookup_a_addr_i,
   input  logic [ADDR_W-1:0] lookup_b_addr_i,
   output logic              busy_a_o,
   output logic              busy_b_o
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DEPTH-1:0] busy_q;
   logic [DEPTH-1:0] busy_d;
   logic             setHit;
   logic             clrHit;

   assign setHit = set_en_i && (set_addr_i != ADDR_W'(REG_ZERO));
   assign clrHit = clr_en_i && (clr_addr_i != ADDR_W'(REG_ZERO));

   // The clear is applied first so that a newer producer issued in the same cycle keeps the bit set.
   always_comb begin
      busy_d = busy_q;
      if (clrHit) busy_d[clr_addr_i] = 1'b0;
      if (setHit) busy_d[set_addr_i] = 1'b1;
      busy_d[REG_ZERO] = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) busy_q <= '0;
      else       busy_q <= busy_d;
   end

   // A write-back landing this cycle already satisfies the reader, matching the data bypass.
   always_comb begin
      busy_a_o = busy_q[lookup_a_addr_i];
      busy_b_o = busy_q[lookup_b_addr_i];
      if (clrHit && (clr_addr_i == lookup_a_addr_i)) busy_a_o = 1'b0;
      if (clrHit && (clr_addr_i == lookup_b_addr_i)) busy_b_o = 1'b0;
      if (reset) begin
         busy_a_o = 1'b0;
         busy_b_o = 1'b0;
      end
   end

endmodule

// File: rtl/register_file.sv
// Two-read, one-write flip-flop register file with write-back bypass and busy-bit scoreboard.
module register_file
   import register_file_pkg::*;
#(
   parameter int DATA_W = CPU_DATA_W,
   parameter int ADDR_W = CPU_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] rs_addr,
   input  logic [ADDR_W-1:0] rt_addr,
   output logic [DATA_W-1:0] rs_data,
   output logic [DATA_W-1:0] rt_data,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              issue_en,
   input  logic [ADDR_W-1:0] issue_addr,
   output logic              rs_busy,
   output logic              rt_busy
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DATA_W-1:0] regs_d [DEPTH];
   logic              wrHit;

   assign wrHit = wr_en && (wr_addr != ADDR_W'(REG_ZERO));

   always_comb begin
      regs_d = regs_q;
      if (wrHit) regs_d[wr_addr] = wr_data;
      regs_d[REG_ZERO] = '0;
   end

   // Plain flops rather than a RAM so the whole array can clear asynchronously.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      end else begin
         regs_q <= regs_d;
      end
   end

   always_comb begin
      rs_data = regs_q[rs_addr];
      rt_data = regs_q[rt_addr];
      if (wrHit && (wr_addr == rs_addr)) rs_data = wr_data;
      if (wrHit && (wr_addr == rt_addr)) rt_data = wr_data;
      if (reset) begin
         rs_data = '0;
         rt_data = '0;
      end
   end

   reg_scoreboard #(
      .ADDR_W (ADDR_W)
   ) u_scoreboard (
      .clk             (clk),
      .reset           (reset),
      .set_en_i        (issue_en),
      .set_addr_i      (issue_addr),
      .clr_en_i        (wr_en),
      .clr_addr_i      (wr_addr),
      .lookup_a_addr_i (rs_addr),
      .lookup_b_addr_i (rt_addr),
      .busy_a_o        (rs_busy),
      .busy_b_o        (rt_busy)
   );

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file: reset, zero register, bypass, scoreboard and sweep.
module tb_register_file;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   logic              clk;
   logic              reset;
   logic [ADDR_W-1:0] rs_addr;
   logic [ADDR_W-1:0] rt_addr;
   logic [DATA_W-1:0] rs_data;
   logic [DATA_W-1:0] rt_data;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              issue_en;
   logic [ADDR_W-1:0] issue_addr;
   logic              rs_busy;
   logic              rt_busy;

   int numCompared;
   int numMismatched;

   register_file #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .rs_addr    (rs_addr),
      .rt_addr    (rt_addr),
      .rs_data    (rs_data),
      .rt_data    (rt_data),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .issue_en   (issue_en),
      .issue_addr (issue_addr),
      .rs_busy    (rs_busy),
      .rt_busy    (rt_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change on the falling edge and settle for 1ns before anything is checked.
   task automatic applyStimulus(input logic rst, input logic we, input logic [ADDR_W-1:0] wa,
                                input logic [DATA_W-1:0] wd, input logic ie,
                                input logic [ADDR_W-1:0] ia, input logic [ADDR_W-1:0] ra,
                                input logic [ADDR_W-1:0] rb);
      @(negedge clk);
      reset      = rst;
      wr_en      = we;
      wr_addr    = wa;
      wr_data    = wd;
      issue_en   = ie;
      issue_addr = ia;
      rs_addr    = ra;
      rt_addr    = rb;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [DATA_W-1:0] observed,
                              input logic [DATA_W-1:0] expected);
      numCompared++;
      if (observed !== expected) begin
         numMismatched++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   function automatic logic [DATA_W-1:0] sweepValue(input int a);
      return (a == 0) ? 32'h0 : 32'(a) * 32'h01010101;
   endfunction

   initial begin
      numCompared   = 0;
      numMismatched = 0;
      reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      issue_en = 1'b0; issue_addr = '0; rs_addr = '0; rt_addr = '0;

      // Reset state
      applyStimulus(1, 0, 0, 0, 0, 0, 5, 9);
      checkOutput("reset_rs_data", rs_data, 32'h0);
      checkOutput("reset_rt_data", rt_data, 32'h0);
      checkOutput("reset_rs_busy", 32'(rs_busy), 32'h0);
      checkOutput("reset_rt_busy", 32'(rt_busy), 32'h0);

      // Zero register ignores writes and issues
      applyStimulus(0, 1, 0, 32'hFFFFFFFF, 1, 0, 0, 0);
      checkOutput("zero_bypass_rs", rs_data, 32'h0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("zero_rs_data", rs_data, 32'h0);
      checkOutput("zero_rs_busy", 32'(rs_busy), 32'h0);

      // Bypass on both ports, then persistence
      applyStimulus(0, 1, 7, 32'h12345678, 0, 0, 7, 7);
      checkOutput("bypass_rs", rs_data, 32'h12345678);
      checkOutput("bypass_rt", rt_data, 32'h12345678);
      applyStimulus(0, 0, 7, 32'h0, 0, 0, 7, 7);
      checkOutput("persist_rs", rs_data, 32'h12345678);
      checkOutput("persist_rt", rt_data, 32'h12345678);

      // wr_en low leaves reg7 alone regardless of address/data
      applyStimulus(0, 0, 7, 32'hCAFEF00D, 0, 0, 7, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 7, 0);
      checkOutput("no_write_reg7", rs_data, 32'h12345678);

      // Scoreboard: issue 9, busy next cycle, clearing write drops it combinationally
      applyStimulus(0, 0, 0, 0, 1, 9, 0, 9);
      checkOutput("sb_c0_rt_busy", 32'(rt_busy), 32'h0);
      applyStimulus(0, 0, 0, 0, 0, 0, 9, 9);
      checkOutput("sb_c1_rt_busy", 32'(rt_busy), 32'h1);
      checkOutput("sb_c1_rs_busy", 32'(rs_busy), 32'h1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 9);
      checkOutput("sb_c2_rt_busy", 32'(rt_busy), 32'h1);
      applyStimulus(0, 1, 9, 32'h00000099, 0, 0, 9, 9);
      checkOutput("sb_c3_rt_busy", 32'(rt_busy), 32'h0);
      checkOutput("sb_c3_rs_busy", 32'(rs_busy), 32'h0);
      checkOutput("sb_c3_rt_data", rt_data, 32'h00000099);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 9);
      checkOutput("sb_c4_rt_busy", 32'(rt_busy), 32'h0);
      checkOutput("sb_c4_rt_data", rt_data, 32'h00000099);

      // A write to a different register does not clear someone else's busy bit
      applyStimulus(0, 0, 0, 0, 1, 20, 0, 0);
      applyStimulus(0, 1, 21, 32'h21, 0, 0, 20, 21);
      checkOutput("sb_other_rs_busy", 32'(rs_busy), 32'h1);
      checkOutput("sb_other_rt_busy", 32'(rt_busy), 32'h0);

      // Set and clear on the same register in one cycle: set wins, data still written
      applyStimulus(0, 1, 12, 32'hA5A5A5A5, 1, 12, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 12, 12);
      checkOutput("setclr_busy", 32'(rs_busy), 32'h1);
      checkOutput("setclr_data", rs_data, 32'hA5A5A5A5);

      // Reset between edges clears state immediately
      applyStimulus(0, 1, 5, 32'hDEADBEEF, 0, 0, 5, 12);
      applyStimulus(0, 0, 0, 0, 0, 0, 5, 12);
      checkOutput("pre_reset_reg5", rs_data, 32'hDEADBEEF);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("async_reset_reg5", rs_data, 32'h0);
      checkOutput("async_reset_busy12", 32'(rt_busy), 32'h0);

      // Writes and issues during reset are ignored, including the bypass path
      applyStimulus(1, 1, 3, 32'h33, 1, 3, 3, 3);
      checkOutput("in_reset_rs_data", rs_data, 32'h0);
      checkOutput("in_reset_rs_busy", 32'(rs_busy), 32'h0);

      // Write and issue coincident with reset release take effect at the next edge
      applyStimulus(0, 1, 4, 32'h44, 1, 4, 12, 20);
      checkOutput("release_busy12", 32'(rs_busy), 32'h0);
      checkOutput("release_busy20", 32'(rt_busy), 32'h0);
      applyStimulus(0, 0, 0, 0, 0, 0, 4, 3);
      checkOutput("release_reg4", rs_data, 32'h44);
      checkOutput("release_busy4", 32'(rs_busy), 32'h1);
      checkOutput("reset_write_reg3", rt_data, 32'h0);
      checkOutput("reset_issue_busy3", 32'(rt_busy), 32'h0);

      // Sweep: fill every register, then read mixed address pairs
      for (int a = 0; a < 32; a++) applyStimulus(0, 1, ADDR_W'(a), sweepValue(a), 0, 0, 0, 0);
      // reg0 was targeted too; its write must not stick
      for (int i = 0; i < 32; i++) begin
         applyStimulus(0, 0, 0, 0, 0, 0, ADDR_W'(i), ADDR_W'((i * 7 + 3) % 32));
         checkOutput($sformatf("sweep_rs_%0d", i), rs_data, sweepValue(i));
         checkOutput($sformatf("sweep_rt_%0d", (i * 7 + 3) % 32), rt_data,
                     sweepValue((i * 7 + 3) % 32));
      end
      applyStimulus(0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 31);
      checkOutput("sweep_reg0", rs_data, 32'h0);
      checkOutput("sweep_reg31", rt_data, 32'h1F1F1F1F);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
      $finish;
   end

endmodule
